tile_buffer_swap_ctrl: RTL and testbench
========================================

Name: tile_buffer_swap_ctrl

Overview:
- Sequences the double-buffered tile-index memory by owning the buffer-select bit that feeds the display/RPi tile-index router.
- Accepts a "frame complete" request from the RPi-side writer and blocks further writes until the swap is done.
- Flips the buffers only on a display vertical-blank rising edge, so the display never changes buffer mid-frame.
- Enforces a minimum display time per buffer and exposes swap/repeat statistics.

Parameters:
- MIN_FRAMES, 1: minimum number of vblank rising edges a buffer must be displayed for before it is swapped out; legal range 1..255.
- CNT_WIDTH, 16: width of the swap_cnt and repeat_cnt statistics counters.

Ports:
- clk  input  1  system clock; all logic in this single domain.
- reset  input  1  asynchronous, active-high reset.
- swap_req  input  1  RPi side has finished writing its buffer; sampled only in IDLE.
- vblank  input  1  display vertical-blank level, synchronous to clk.
- tile_idx_select  output  1  buffer select to the tile-index router (0: display reads buffer 0, RPi writes buffer 1).
- rpi_wr_allow  output  1  RPi may write the back buffer; the RPi write-enable is ANDed with this signal upstream.
- swap_pending  output  1  request accepted, waiting for a qualifying vblank.
- swap_done  output  1  one-cycle pulse in the cycle after the select flip.
- swap_cnt  output  CNT_WIDTH  number of swaps performed; wraps.
- repeat_cnt  output  CNT_WIDTH  number of vblank rising edges with no swap (display reshows a frame); wraps.

Behaviour:
- Reset (async, immediate, mid-operation included):
  - state=IDLE, tile_idx_select=0, swap_done=0, swap_pending=0, rpi_wr_allow=1.
  - swap_cnt=0, repeat_cnt=0, vblank_q=0.
  - frames_shown=MIN_FRAMES (saturated), so the first qualifying edge may swap.
- Edge detect: vb_edge = vblank & ~vblank_q; vblank_q is registered every cycle.
  - vblank held high produces exactly one edge.
  - vblank already high in the first cycle after reset counts as an edge.
- frames_shown:
  - Counts vb_edge events since the last swap and saturates at MIN_FRAMES.
  - Cleared to 0 on a swap; the swap edge itself is not counted.
- qualify = vb_edge & (frames_shown + 1 >= MIN_FRAMES). Compare with width wide enough to avoid overflow.
- States (registered):
  - IDLE: rpi_wr_allow=1, swap_pending=0. If swap_req=1, go to PENDING next cycle.
  - PENDING: rpi_wr_allow=0, swap_pending=1. swap_req is ignored. If qualify, perform the swap at the end of this cycle and return to IDLE.
- Swap at the end of cycle t:
  - tile_idx_select toggles.
  - swap_cnt increments; frames_shown clears.
  - In cycle t+1: swap_done=1 for that cycle only, state=IDLE, rpi_wr_allow=1.
  - Writes in t+1 therefore land in the new back buffer.
- Output timing: rpi_wr_allow and swap_pending are decoded directly from the state register (no combinational path from inputs). swap_done is a registered pulse.
- repeat_cnt increments on every vb_edge that does not cause a swap, in either state.
- Simultaneous swap_req and vb_edge in IDLE: the request is accepted and that edge is not used for a swap. It counts as a repeat and increments frames_shown. The swap occurs at a later qualifying edge.
- swap_req held high continuously: after each swap the block re-enters PENDING one cycle after returning to IDLE. This gives back-to-back swaps at every qualifying edge.
- Counter wrap: swap_cnt and repeat_cnt roll over from all-ones to 0 with no flag.
- swap_req has no effect while in PENDING or during reset; the request is not queued.

Test Plan:
- Reset check: assert reset mid-cycle, then release -> immediately tile_idx_select=0, rpi_wr_allow=1, swap_pending=0, swap_done=0, both counters 0.
- Basic swap, MIN_FRAMES=1:
  - Stimulus: swap_req pulse in cycle 10, vblank rises in cycle 20 and is held for 50 cycles.
  - Response: rpi_wr_allow=0 in cycles 11-20; tile_idx_select=1 from cycle 21; swap_done=1 only in cycle 21; swap_cnt=1, repeat_cnt=0.
- Idle repeats: three vblank pulses with no request -> repeat_cnt=3, tile_idx_select unchanged, swap_done never asserted.
- Collision: swap_req and a vblank rising edge in the same IDLE cycle -> no flip at that edge and repeat_cnt=1. The next vblank edge flips select and swap_cnt=1.
- Hold, MIN_FRAMES=2:
  - Stimulus: after a swap, swap_req is issued immediately.
  - Response: the first following edge gives no swap and repeat_cnt+1; the second edge swaps.
  - With swap_req held high over 6 edges: exactly 3 swaps.
- Reset mid-PENDING: assert reset while swap_pending=1 and select=1 -> same cycle: select=0, swap_pending=0, rpi_wr_allow=1. After release, the next vblank edge causes no swap.

Source files
------------

// File: rtl/tile_buffer_swap_ctrl_if.sv
// tile_buffer_swap_ctrl_if: request/vblank inputs and select/status outputs of the swap controller
interface tile_buffer_swap_ctrl_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 swap_req;
    logic                 vblank;
    logic                 tile_idx_select;
    logic                 rpi_wr_allow;
    logic                 swap_pending;
    logic                 swap_done;
    logic [CNT_WIDTH-1:0] swap_cnt;
    logic [CNT_WIDTH-1:0] repeat_cnt;
    modport master (
        output swap_req, vblank,
        input  tile_idx_select, rpi_wr_allow, swap_pending, swap_done, swap_cnt, repeat_cnt
    );
    modport slave (
        input  swap_req, vblank,
        output tile_idx_select, rpi_wr_allow, swap_pending, swap_done, swap_cnt, repeat_cnt
    );
endinterface

// File: rtl/tile_buffer_swap_ctrl.sv
// tile_buffer_swap_ctrl: flips the double-buffer select on a qualifying vblank edge after a frame-complete request
module tile_buffer_swap_ctrl #(
    parameter int MIN_FRAMES = 1,
    parameter int CNT_WIDTH  = 16
) (
    input logic                    clk,
    input logic                    reset,
    tile_buffer_swap_ctrl_if.slave bus
);
    typedef enum logic {IDLE, PENDING} state_t;
    state_t               state_q, state_d;
    logic                 sel_q, sel_d;
    logic                 done_q, done_d;
    logic                 vblank_q;
    logic [7:0]           frames_q, frames_d;
    logic [CNT_WIDTH-1:0] swap_cnt_q, swap_cnt_d;
    logic [CNT_WIDTH-1:0] repeat_cnt_q, repeat_cnt_d;
    logic                 vb_edge, qualify, do_swap;

    assign vb_edge = bus.vblank & ~vblank_q;
    assign qualify = vb_edge & (({1'b0, frames_q} + 9'd1) >= 9'(MIN_FRAMES));
    assign do_swap = (state_q == PENDING) & qualify;

    // next state: accept requests in IDLE, swap on a qualifying edge in PENDING, count every other edge as a repeat
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        done_d       = do_swap;
        frames_d     = frames_q;
        swap_cnt_d   = swap_cnt_q;
        repeat_cnt_d = repeat_cnt_q;
        if (state_q == IDLE)
            state_d = bus.swap_req ? PENDING : IDLE;
        else if (do_swap)
            state_d = IDLE;
        if (do_swap) begin
            sel_d      = ~sel_q;
            swap_cnt_d = swap_cnt_q + 1'b1;
            frames_d   = 8'd0;
        end else if (vb_edge) begin
            repeat_cnt_d = repeat_cnt_q + 1'b1;
            frames_d     = (frames_q < 8'(MIN_FRAMES)) ? frames_q + 8'd1 : frames_q;
        end
    end

    // state and statistics registers; frames_shown starts saturated so the first qualifying edge may swap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            sel_q        <= 1'b0;
            done_q       <= 1'b0;
            vblank_q     <= 1'b0;
            frames_q     <= 8'(MIN_FRAMES);
            swap_cnt_q   <= '0;
            repeat_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            done_q       <= done_d;
            vblank_q     <= bus.vblank;
            frames_q     <= frames_d;
            swap_cnt_q   <= swap_cnt_d;
            repeat_cnt_q <= repeat_cnt_d;
        end
    end

    assign bus.tile_idx_select = sel_q;
    assign bus.rpi_wr_allow    = (state_q == IDLE);
    assign bus.swap_pending    = (state_q == PENDING);
    assign bus.swap_done       = done_q;
    assign bus.swap_cnt        = swap_cnt_q;
    assign bus.repeat_cnt      = repeat_cnt_q;
endmodule

// File: tb/tb_tile_buffer_swap_ctrl.sv
// tb_tile_buffer_swap_ctrl: directed vector table plus hand-written multi-cycle sequences
module tb_tile_buffer_swap_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    tile_buffer_swap_ctrl_if #(.CNT_WIDTH(16)) ifa ();
    tile_buffer_swap_ctrl_if #(.CNT_WIDTH(2))  ifb ();

    tile_buffer_swap_ctrl #(.MIN_FRAMES(1), .CNT_WIDTH(16)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    tile_buffer_swap_ctrl #(.MIN_FRAMES(2), .CNT_WIDTH(2))  dut_b (.clk(clk), .reset(reset), .bus(ifb));

    typedef struct {
        logic        req;
        logic        vb;
        logic        sel;
        logic        wr;
        logic        pend;
        logic        done;
        logic [15:0] sc;
        logic [15:0] rc;
    } vec_t;

    vec_t vec [15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [63:0] snap_a();
        return {28'd0, ifa.tile_idx_select, ifa.rpi_wr_allow, ifa.swap_pending, ifa.swap_done, ifa.swap_cnt, ifa.repeat_cnt};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1 chk("async_reset", snap_a(), {28'd0, 4'b0100, 32'd0});
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic       done_seen;
        logic [6:0] b_sel_exp;
        //            req vb  sel wr pend done sc rc
        vec[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0};
        vec[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0};
        vec[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0};
        vec[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'd1, 16'd0};
        vec[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1, 16'd0};
        vec[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1, 16'd0};
        vec[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1, 16'd1};
        vec[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1, 16'd1};
        vec[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1, 16'd2};
        vec[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1, 16'd2};
        vec[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2, 16'd2};
        vec[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2, 16'd2};
        vec[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2, 16'd2};
        vec[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'd3, 16'd2};
        vec[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd3, 16'd2};
        ifa.swap_req = 1'b0;
        ifa.vblank   = 1'b0;
        ifb.swap_req = 1'b0;
        ifb.vblank   = 1'b0;

        #12 reset = 1'b0;
        #1 chk("reset_state", snap_a(), {28'd0, 4'b0100, 32'd0});
        @(negedge clk);

        for (int c = 0; c < 80; c++) begin
            ifa.swap_req = (c == 10);
            ifa.vblank   = (c >= 20 && c < 70);
            chk($sformatf("basic_c%0d", c),
                {61'd0, ifa.tile_idx_select, ifa.rpi_wr_allow, ifa.swap_done},
                {61'd0, c >= 21, !(c >= 11 && c <= 20), c == 21});
            cyc();
        end
        chk("basic_counts", {ifa.swap_cnt, ifa.repeat_cnt}, {16'd1, 16'd0});

        done_seen = 1'b0;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 4; k++) begin
                ifa.vblank = (k < 2);
                cyc();
                done_seen |= ifa.swap_done;
            end
        end
        chk("idle_repeats", {29'd0, done_seen, ifa.tile_idx_select, ifa.repeat_cnt, ifa.swap_cnt},
            {29'd0, 1'b0, 1'b1, 16'd3, 16'd1});

        do_reset();
        for (int i = 0; i < 15; i++) begin
            ifa.swap_req = vec[i].req;
            ifa.vblank   = vec[i].vb;
            cyc();
            chk($sformatf("vec%0d", i), snap_a(),
                {28'd0, vec[i].sel, vec[i].wr, vec[i].pend, vec[i].done, vec[i].sc, vec[i].rc});
        end

        ifa.swap_req = 1'b1;
        cyc();
        ifa.swap_req = 1'b0;
        chk("pend_before_reset", {62'd0, ifa.tile_idx_select, ifa.swap_pending}, 64'd3);
        #2 reset = 1'b1;
        #1 chk("reset_mid_pending", {61'd0, ifa.tile_idx_select, ifa.swap_pending, ifa.rpi_wr_allow}, 64'd1);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ifa.vblank = (k < 2);
            cyc();
            done_seen |= ifa.swap_done;
        end
        chk("after_reset_no_swap", {31'd0, done_seen, ifa.tile_idx_select, ifa.swap_cnt, ifa.repeat_cnt},
            {31'd0, 1'b0, 1'b0, 16'd0, 16'd1});

        do_reset();
        b_sel_exp = 7'b0110011;
        ifb.swap_req = 1'b1;
        cyc();
        cyc();
        chk("b_pending", {63'd0, ifb.swap_pending}, 64'd1);
        for (int e = 0; e < 7; e++) begin
            for (int k = 0; k < 6; k++) begin
                ifb.vblank = (k < 3);
                cyc();
            end
            chk($sformatf("b_edge%0d_sel", e + 1), {63'd0, ifb.tile_idx_select}, {63'd0, b_sel_exp[e]});
            if (e == 5)
                chk("b_six_edges", {60'd0, ifb.swap_cnt, ifb.repeat_cnt}, {60'd0, 2'd3, 2'd3});
        end
        chk("b_swap_wrap", {60'd0, ifb.swap_cnt, ifb.repeat_cnt}, {60'd0, 2'd0, 2'd3});
        ifb.swap_req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            ifb.vblank = (k < 3);
            cyc();
        end
        chk("b_repeat_wrap", {61'd0, ifb.tile_idx_select, ifb.repeat_cnt}, {61'd0, 1'b0, 2'd0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
